// File: rtl/kamacore_fetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches under a credit limit,
// pairs in-order responses with their PC and queues them for the IF stage.
module kamacore_fetch_buffer #(
    parameter int                   CPU_WIDTH = 32,
    parameter int                   DEPTH     = 4,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [CPU_WIDTH-1:0] imem_rsp_data,
    input  logic                 branch_valid,
    input  logic [CPU_WIDTH-1:0] branch_target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CPU_WIDTH-1:0] out_pc,
    output logic [CPU_WIDTH-1:0] out_instr
);
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam int             CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [CPU_WIDTH-1:0] fetch_pc;
    logic [CPU_WIDTH-1:0] fifo_pc    [DEPTH];
    logic [CPU_WIDTH-1:0] fifo_instr [DEPTH];
    logic [CPU_WIDTH-1:0] pcq        [DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr, pcq_rd, pcq_wr;
    logic [CNT_W-1:0]     count, outstanding, drop;

    logic                 req_fire, push, pop;
    logic [CNT_W:0]       credit_used;
    logic [CPU_WIDTH-1:0] target_aligned;
    logic                 unused_target_bits;

    assign target_aligned     = {branch_target[CPU_WIDTH-1:2], 2'b00};
    assign unused_target_bits = ^branch_target[1:0];

    // Every in-flight request owns a FIFO slot, so responses never overflow.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !branch_valid && (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push = imem_rsp_valid && (drop == '0) && !branch_valid;
    assign pop  = out_valid && out_ready && !branch_valid;

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;
    assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            if (branch_valid)
                fetch_pc <= target_aligned;
            else if (req_fire)
                fetch_pc <= fetch_pc + CPU_WIDTH'(4);

            if (req_fire)
                pcq_wr <= pcq_wr + 1'b1;
            if (imem_rsp_valid)
                pcq_rd <= pcq_rd + 1'b1;
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

            if (branch_valid) begin
                // Everything still in flight is stale, including this cycle's response.
                drop   <= outstanding - CNT_W'(imem_rsp_valid);
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (imem_rsp_valid && (drop != '0))
                    drop <= drop - 1'b1;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // NOTE: storage arrays carry no reset; pointers and count define validity,
    // so clearing the contents would only cost reset routing.
    always_ff @(posedge clk) begin
        if (req_fire)
            pcq[pcq_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]    <= pcq[pcq_rd];
            fifo_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    rsp_without_request: assert property (
        @(posedge clk) disable iff (rst) imem_rsp_valid |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_kamacore_fetch_buffer.sv
// Self-checking bench for kamacore_fetch_buffer: in-order memory model with
// configurable latency and a scoreboard of expected {pc, instr} pops.
module tb_kamacore_fetch_buffer;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] INSTR_KEY = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    mreq_t       mq[$];
    ent_t        exp_q[$];
    logic [31:0] exp_addr;
    int          cyc;
    int          lat;
    int          fire_cnt;
    int          pop_cnt;
    int          passed;
    int          total;

    kamacore_fetch_buffer #(
        .CPU_WIDTH (32),
        .DEPTH     (4),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model and scoreboard; acts 2 time units after each falling edge,
    // after the tests have driven that cycle's inputs.
    task automatic monitor();
        mreq_t r;
        ent_t  e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst) begin
                mq.delete();
                exp_q.delete();
                exp_addr       = RESET_PC;
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
                fire_cnt       = 0;
                pop_cnt        = 0;
            end else begin
                if (mq.size() != 0 && mq[0].due <= cyc) begin
                    r = mq.pop_front();
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = r.addr ^ INSTR_KEY;
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = '0;
                end
                if (branch_valid) begin
                    exp_q.delete();
                    exp_addr = {branch_target[31:2], 2'b00};
                end else if (out_valid && out_ready) begin
                    total++;
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL scoreboard_pop: got pc=%h instr=%h, expected no entry", out_pc, out_instr);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_pc !== e.pc || out_instr !== e.instr)
                            $display("FAIL scoreboard_pop: got pc=%h instr=%h, expected pc=%h instr=%h",
                                     out_pc, out_instr, e.pc, e.instr);
                        else
                            passed++;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    total++;
                    fire_cnt++;
                    if (imem_req_addr !== exp_addr)
                        $display("FAIL req_addr: got %h, expected %h", imem_req_addr, exp_addr);
                    else
                        passed++;
                    mq.push_back('{imem_req_addr, cyc + lat});
                    exp_q.push_back('{exp_addr, exp_addr ^ INSTR_KEY});
                    exp_addr = exp_addr + 32'd4;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        branch_valid   = 1'b0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #4;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b, expected 0", imem_req_valid); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, expected 0", out_valid); else passed++;
        total++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc: got %h, expected 0", out_pc); else passed++;
        total++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr: got %h, expected 0", out_instr); else passed++;
        total++; if (imem_req_addr !== RESET_PC) $display("FAIL reset_req_addr: got %h, expected %h", imem_req_addr, RESET_PC); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        int first_fire;
        int lag;
        bit found;
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        first_fire = -1; found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #4;
            if (first_fire < 0 && imem_req_valid && imem_req_ready) first_fire = cyc;
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        lag = cyc - first_fire;
        total++; if (!found) $display("FAIL stream_first_valid: got no out_valid, expected one within 20 cycles"); else passed++;
        total++; if (lag != 2) $display("FAIL stream_latency: got %0d cycles, expected 2", lag); else passed++;
        total++; if (out_pc !== 32'h0) $display("FAIL stream_first_pc: got %h, expected 0", out_pc); else passed++;
        total++; if (out_instr !== INSTR_KEY) $display("FAIL stream_first_instr: got %h, expected %h", out_instr, INSTR_KEY); else passed++;
        repeat (20) @(negedge clk);
        #4;
        total++; if (pop_cnt < 15) $display("FAIL stream_throughput: got %0d pops, expected at least 15", pop_cnt); else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
        repeat (10) @(negedge clk);
        #4;
        total++; if (fire_cnt != 4) $display("FAIL bp_fire_count: got %0d, expected 4", fire_cnt); else passed++;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL bp_req_stalled: got %b, expected 0", imem_req_valid); else passed++;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) $display("FAIL bp_head: got valid=%b pc=%h, expected 1/0", out_valid, out_pc); else passed++;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && pop_cnt < 8; i++) @(negedge clk);
        #4;
        total++; if (pop_cnt < 8) $display("FAIL bp_drain: got %0d pops, expected at least 8", pop_cnt); else passed++;
        total++; if (fire_cnt <= 4) $display("FAIL bp_resume: got %0d fires, expected more than 4", fire_cnt); else passed++;
    endtask

    task automatic test_redirect_inflight();
        bit found;
        do_reset();
        lat = 3; out_ready = 1'b1; imem_req_ready = 1'b0;
        branch_valid = 1'b1; branch_target = 32'h20;
        @(negedge clk);
        branch_valid = 1'b0; imem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        branch_valid = 1'b1; branch_target = 32'h103;
        #4;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL inflight_no_req: got %b, expected 0", imem_req_valid); else passed++;
        @(negedge clk);
        branch_valid = 1'b0;
        #4;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100)
            $display("FAIL inflight_target_req: got valid=%b addr=%h, expected 1/00000100", imem_req_valid, imem_req_addr); else passed++;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            #4;
        end
        total++; if (!found || out_pc !== 32'h100 || out_instr !== (32'h100 ^ INSTR_KEY))
            $display("FAIL inflight_first_out: got found=%b pc=%h instr=%h, expected pc=00000100", found, out_pc, out_instr); else passed++;
    endtask

    task automatic test_redirect_coincident();
        int branch_cyc;
        int lag;
        do_reset();
        lat = 2; out_ready = 1'b1; imem_req_ready = 1'b0;
        branch_valid = 1'b1; branch_target = 32'h40;
        @(negedge clk);
        branch_valid = 1'b0; imem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        branch_valid = 1'b1; branch_target = 32'h200;
        #4;
        branch_cyc = cyc;
        @(negedge clk);
        branch_valid = 1'b0;
        lag = -1;
        for (int i = 0; i < 20; i++) begin
            #4;
            if (out_valid) begin
                lag = cyc - branch_cyc;
                break;
            end
            @(negedge clk);
        end
        total++; if (lag != 4) $display("FAIL coincident_gap: got %0d cycles to out_valid, expected 4", lag); else passed++;
        total++; if (out_pc !== 32'h200 || out_instr !== (32'h200 ^ INSTR_KEY))
            $display("FAIL coincident_first_out: got pc=%h instr=%h, expected pc=00000200", out_pc, out_instr); else passed++;
    endtask

    task automatic test_redirect_pop();
        int seen;
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        imem_req_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1; branch_valid = 1'b1; branch_target = 32'h300;
        #4;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) $display("FAIL pop_pre_state: got valid=%b pc=%h, expected 1/0", out_valid, out_pc); else passed++;
        @(negedge clk);
        branch_valid = 1'b0;
        #4;
        total++; if (out_valid !== 1'b0) $display("FAIL pop_cleared: got %b, expected 0", out_valid); else passed++;
        total++; if (imem_req_addr !== 32'h300) $display("FAIL pop_fetch_pc: got %h, expected 00000300", imem_req_addr); else passed++;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #4;
            if (out_valid) seen++;
        end
        total++; if (seen != 0) $display("FAIL pop_no_entry: got %0d valid cycles, expected 0", seen); else passed++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        total++; if (out_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %b, expected 1", out_valid); else passed++;
        #3;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0)
            $display("FAIL midrst_async: got out_valid=%b req_valid=%b, expected 0/0", out_valid, imem_req_valid); else passed++;
        total++; if (out_pc !== 32'h0) $display("FAIL midrst_out_pc: got %h, expected 0", out_pc); else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #4;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC)
            $display("FAIL midrst_first_req: got valid=%b addr=%h, expected 1/%h", imem_req_valid, imem_req_addr, RESET_PC); else passed++;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #4;
        total++; if (pop_cnt < 4) $display("FAIL midrst_stream: got %0d pops, expected at least 4", pop_cnt); else passed++;
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        branch_valid   = 1'b0;
        branch_target  = '0;
        out_ready      = 1'b0;
        exp_addr       = RESET_PC;
        cyc = 0; lat = 1; fire_cnt = 0; pop_cnt = 0; passed = 0; total = 0;
        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog: simulation did not finish within time limit");
                $fatal(1);
            end
        join_none
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_redirect_pop();
        test_mid_reset();
        do_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/kamacore_fetch_buffer.md
Name: kamacore_fetch_buffer

Overview:
Instruction prefetch unit directly upstream of the IF stage. It generates sequential fetch addresses, issues requests to instruction memory over a valid/ready channel, and queues in-order responses with their PC in a small FIFO. The IF stage drains the FIFO through a valid/ready handshake. A branch redirect from the pipeline flushes the queue and discards responses that are still in flight.

Parameters:
CPU_WIDTH, 32, width of PC and instruction words
DEPTH, 4, FIFO entries; must be a power of two, at least 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts the request
imem_req_addr  output  CPU_WIDTH  fetch address, word aligned
imem_rsp_valid  input  1  response valid; responses return in request order, latency ≥1 cycle, arbitrary
imem_rsp_data  input  CPU_WIDTH  fetched instruction
branch_valid  input  1  redirect request from the pipeline
branch_target  input  CPU_WIDTH  redirect PC; bits [1:0] ignored, treated as 0
out_valid  output  1  head entry available to the IF stage
out_ready  input  1  IF stage consumes the head entry
out_pc  output  CPU_WIDTH  PC of the head entry
out_instr  output  CPU_WIDTH  instruction of the head entry

Behaviour:
- Reset (asynchronous, active-high): fetch_pc=RESET_PC, FIFO empty (rd/wr pointers 0, count 0), outstanding=0, drop=0. While reset is asserted: imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0, imem_req_addr=RESET_PC.
- State:
  - fetch_pc
  - FIFO of DEPTH {pc, instr} entries
  - count: 0..DEPTH
  - outstanding: 0..DEPTH, number of accepted requests without a response
  - drop: 0..outstanding, responses still to be discarded
  - pc_q: FIFO of DEPTH PCs for in-flight requests, so each response is paired with its PC
- Credit rule: imem_req_valid = !branch_valid && (count + outstanding < DEPTH). This guarantees FIFO space for every response. imem_req_addr = fetch_pc. Both are combinational from state.
- Request fire (valid && ready): push fetch_pc onto pc_q, fetch_pc += 4 (modulo 2^CPU_WIDTH), outstanding += 1.
- Response arrival (imem_rsp_valid):
  - Always: outstanding −= 1 and pop pc_q.
  - If drop>0: drop −= 1 and discard the data.
  - Otherwise: push {popped pc, imem_rsp_data} into the FIFO.
- Response latency to output: a response accepted in cycle N is visible on out_valid/out_instr in cycle N+1. There is no bypass.
- Output: out_valid = (count != 0). out_pc and out_instr show the head entry, or 0 when the FIFO is empty. Pop when out_valid && out_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Redirect (branch_valid high in cycle N). At the clock edge:
  - fetch_pc = {branch_target[CPU_WIDTH-1:2], 2'b00}.
  - FIFO cleared: count=0, pointers reset.
  - drop = outstanding − imem_rsp_valid. The response arriving in cycle N is itself discarded.
  - A pop in the same cycle is ignored, because the FIFO is cleared anyway.
  - No request is issued in cycle N.
  - In cycle N+1 the first request is to the target, provided credit allows.
- Back-to-back redirects: the last one wins. drop accumulates correctly because it tracks outstanding.
- An imem_rsp_valid when outstanding=0 is a protocol violation. Flag it with an assertion; it has no defined effect.
- Reset mid-operation: all state clears immediately. Responses to requests issued before reset are not tracked; the memory model must be reset together with this block.

Test Plan:
- Streaming: release reset, memory ready=1, latency 1, instr=addr^32'hA5A5_0000, out_ready=1 → out_pc sequence 0,4,8,12,… with matching out_instr; first out_valid exactly 2 cycles after the first request fire.
- Backpressure: out_ready=0, latency 1 → exactly 4 (DEPTH) requests issued (addresses 0..12), then imem_req_valid=0. Raise out_ready → entries drain in order and fetching resumes at 16. Pointer wrap is exercised.
- Redirect with in-flight: latency 3, two requests outstanding (0x20, 0x24), assert branch_valid with target 0x103 → next request addr 0x100. Both stale responses are dropped. The first out_pc after the redirect is 0x100.
- Redirect coincident with response: branch_valid and imem_rsp_valid (for PC 0x40) in the same cycle with one more request outstanding → neither is enqueued; out_valid stays 0 until the 0x200 response arrives.
- Redirect with simultaneous pop: FIFO holds 2 entries, out_ready=1 and branch_valid=1 → count becomes 0 and no entry appears afterwards.
- Mid-run reset: assert rst asynchronously between clock edges with the FIFO non-empty → out_valid and imem_req_valid drop immediately. After release, the first request addr is RESET_PC.
